ds1302_bcd_to_bin: RTL and testbench

//   Converts the BCD time registers read from the DS1302 (seconds, minutes, hours bytes) into

---
 rtl/ds1302_bcd_to_bin.sv | 158 +++++++++++++++
 tb/tb_ds1302_bcd_to_bin.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_bcd_to_bin.sv
// DS1302 BCD time registers (sec/min/hr) to binary, one field per cycle through a
// shared tens*10+units adder, presented on a valid/ready handshake.
module ds1302_bcd_to_bin #(
    parameter bit CONV_12H  = 1'b1,
    parameter bit RANGE_CHK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] sec_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] hr_bcd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] sec_out,
    output logic [5:0] min_out,
    output logic [4:0] hr_out,
    output logic       pm,
    output logic       clock_halt,
    output logic       bcd_err
);

    typedef enum logic [2:0] {IDLE, SEC, MIN, HR, DONE} state_t;

    state_t     state_reg, state_next;
    logic [7:0] sec_bcd_reg;
    logic [6:0] min_bcd_reg;
    logic [6:0] hr_bcd_reg;   // {12/24n, PM/tens[1], tens[0], units[3:0]}

    logic [2:0] tens;
    logic [3:0] units;
    logic [6:0] sum;
    logic       digit_err;
    logic       range_err;
    logic       field_err;
    logic [6:0] hr_conv;
    logic       mode_12h;
    logic       pm_bit;

    // Bits of the DS1302 registers that carry nothing for this conversion.
    logic unused_bits;
    assign unused_bits = ^{min_bcd[7], hr_bcd[6]};

    assign in_ready = (state_reg == IDLE) && !rst;
    assign mode_12h = hr_bcd_reg[6];
    assign pm_bit   = hr_bcd_reg[5];

    // Operand select for the single shared x10 adder.
    always_comb begin
        tens  = 3'd0;
        units = 4'd0;
        case (state_reg)
            SEC: begin
                tens  = sec_bcd_reg[6:4];
                units = sec_bcd_reg[3:0];
            end
            MIN: begin
                tens  = min_bcd_reg[6:4];
                units = min_bcd_reg[3:0];
            end
            HR: begin
                tens  = mode_12h ? {2'b00, hr_bcd_reg[4]} : {1'b0, hr_bcd_reg[5:4]};
                units = hr_bcd_reg[3:0];
            end
            default: begin
                tens  = 3'd0;
                units = 4'd0;
            end
        endcase
    end

    assign sum       = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {3'b000, units};
    assign digit_err = (units > 4'd9);

    always_comb begin
        range_err = 1'b0;
        case (state_reg)
            SEC, MIN: range_err = (sum > 7'd59);
            HR:       range_err = mode_12h ? ((sum == 7'd0) || (sum > 7'd12)) : (sum > 7'd23);
            default:  range_err = 1'b0;
        endcase
    end

    assign field_err = digit_err || (RANGE_CHK && range_err);

    // 12 o'clock folds to 0 before the PM offset is added.
    always_comb begin
        hr_conv = sum;
        if (mode_12h && CONV_12H) begin
            if (sum == 7'd12) begin
                hr_conv = pm_bit ? 7'd12 : 7'd0;
            end else begin
                hr_conv = pm_bit ? (sum + 7'd12) : sum;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = SEC;
            SEC:     state_next = MIN;
            MIN:     state_next = HR;
            HR:      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            sec_bcd_reg <= '0;
            min_bcd_reg <= '0;
            hr_bcd_reg  <= '0;
            sec_out     <= '0;
            min_out     <= '0;
            hr_out      <= '0;
            pm          <= 1'b0;
            clock_halt  <= 1'b0;
            bcd_err     <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sec_bcd_reg <= sec_bcd;
                        min_bcd_reg <= min_bcd[6:0];
                        hr_bcd_reg  <= {hr_bcd[7], hr_bcd[5:0]};
                        bcd_err     <= 1'b0;
                    end
                end
                SEC: begin
                    sec_out    <= field_err ? 6'd0 : sum[5:0];
                    clock_halt <= sec_bcd_reg[7];
                    bcd_err    <= bcd_err | field_err;
                end
                MIN: begin
                    min_out <= field_err ? 6'd0 : sum[5:0];
                    bcd_err <= bcd_err | field_err;
                end
                HR: begin
                    hr_out    <= field_err ? 5'd0 : hr_conv[4:0];
                    pm        <= mode_12h & pm_bit;
                    bcd_err   <= bcd_err | field_err;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ds1302_bcd_to_bin.sv
// Directed and random reads of ds1302_bcd_to_bin checked against an arithmetic
// model of the DS1302 time-register rules.
module tb_ds1302_bcd_to_bin;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sec_bcd, min_bcd, hr_bcd;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] sec_out, min_out;
    logic [4:0] hr_out;
    logic       pm, clock_halt, bcd_err;

    int n_assert = 0;
    int n_fail   = 0;

    ds1302_bcd_to_bin #(.CONV_12H(1'b1), .RANGE_CHK(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sec_bcd    (sec_bcd),
        .min_bcd    (min_bcd),
        .hr_bcd     (hr_bcd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sec_out    (sec_out),
        .min_out    (min_out),
        .hr_out     (hr_out),
        .pm         (pm),
        .clock_halt (clock_halt),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Time-keeping rules stated directly: value = tens*10 + units, bad digits or
    // out-of-range values give 0 and an error; 12h hours map via h mod 12 (+12 if PM).
    function automatic void model(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                                  output int es, output int em, output int eh,
                                  output int epm, output int ech, output int eerr);
        int  v;
        bit  bad;
        eerr = 0;
        ech  = int'(s[7]);
        v   = int'(s[6:4]) * 10 + int'(s[3:0]);
        bad = (s[3:0] > 9) || (v > 59);
        es  = bad ? 0 : v;
        eerr = eerr | int'(bad);
        v   = int'(m[6:4]) * 10 + int'(m[3:0]);
        bad = (m[3:0] > 9) || (v > 59);
        em  = bad ? 0 : v;
        eerr = eerr | int'(bad);
        if (h[7]) begin
            epm = int'(h[5]);
            v   = int'(h[4]) * 10 + int'(h[3:0]);
            bad = (h[3:0] > 9) || (v < 1) || (v > 12);
            eh  = bad ? 0 : (v % 12) + (epm != 0 ? 12 : 0);
        end else begin
            epm = 0;
            v   = int'(h[5:4]) * 10 + int'(h[3:0]);
            bad = (h[3:0] > 9) || (v > 23);
            eh  = bad ? 0 : v;
        end
        eerr = eerr | int'(bad);
    endfunction

    task automatic check_fields(input string tag, input int es, input int em, input int eh,
                                input int epm, input int ech, input int eerr);
        chk({tag, ".sec"}, 32'(sec_out), es);
        chk({tag, ".min"}, 32'(min_out), em);
        chk({tag, ".hr"},  32'(hr_out),  eh);
        chk({tag, ".pm"},  32'(pm),      epm);
        chk({tag, ".ch"},  32'(clock_halt), ech);
        chk({tag, ".err"}, 32'(bcd_err), eerr);
    endtask

    // One full read: offer, accept, latency, optional backpressure, handshake.
    task automatic xact(input string tag, input logic [7:0] s, input logic [7:0] m,
                        input logic [7:0] h, input int stall);
        int es, em, eh, epm, ech, eerr, n;
        model(s, m, h, es, em, eh, epm, ech, eerr);
        sec_bcd  = s;
        min_bcd  = m;
        hr_bcd   = h;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, ".accept_ready"}, 32'(in_ready), 1);
        @(posedge clk); #1;
        // Garbage on the inputs while busy must be ignored.
        sec_bcd = 8'($urandom);
        min_bcd = 8'($urandom);
        hr_bcd  = 8'($urandom);
        chk({tag, ".busy_ready"}, 32'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, ".latency"}, n, 3);
        for (int i = 0; i < stall; i++) begin
            check_fields({tag, ".stall"}, es, em, eh, epm, ech, eerr);
            chk({tag, ".stall_valid"}, 32'(out_valid), 1);
            chk({tag, ".stall_ready"}, 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        check_fields(tag, es, em, eh, epm, ech, eerr);
        chk({tag, ".valid"}, 32'(out_valid), 1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(out_valid), 0);
        chk({tag, ".post_ready"}, 32'(in_ready), 1);
        check_fields({tag, ".hold"}, es, em, eh, epm, ech, eerr);
        $display("%s: sec=%02h min=%02h hr=%02h -> %0d/%0d/%0d pm=%0d ch=%0d err=%0d",
                 tag, s, m, h, sec_out, min_out, hr_out, pm, clock_halt, bcd_err);
    endtask

    initial begin
        int n;
        logic [7:0] rs, rm, rh;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sec_bcd   = 8'h00;
        min_bcd   = 8'h00;
        hr_bcd    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", 32'(in_ready), 0);
        check_fields("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.valid", 32'(out_valid), 0);
        rst = 1'b0;
        #1;
        chk("reset.ready_release", 32'(in_ready), 1);

        xact("t1_24h",   8'h45, 8'h30, 8'h13, 0);
        xact("t2_12pm",  8'h00, 8'h00, 8'hB2, 0);
        xact("t2_12am",  8'h01, 8'h02, 8'h92, 0);
        xact("t2_7pm",   8'h10, 8'h20, 8'hA7, 0);
        xact("t2_1am",   8'h11, 8'h22, 8'h81, 0);
        xact("t3_ch",    8'h80, 8'h15, 8'h08, 0);
        xact("t3_digit", 8'h5A, 8'h42, 8'h21, 0);
        xact("t4_max",   8'h59, 8'h59, 8'h23, 0);
        xact("t4_sec60", 8'h60, 8'h12, 8'h05, 0);
        xact("t4_min60", 8'h33, 8'h60, 8'h05, 0);
        xact("t4_hr24",  8'h33, 8'h12, 8'h24, 0);
        xact("t4_hr12z", 8'h33, 8'h12, 8'h80, 0);
        xact("t4_hr13",  8'h33, 8'h12, 8'h93, 0);
        xact("t5_bp",    8'h27, 8'h38, 8'hB1, 6);

        // Reset while the MIN field is being converted.
        sec_bcd  = 8'h12;
        min_bcd  = 8'h34;
        hr_bcd   = 8'h15;
        in_valid = 1'b1;
        @(posedge clk); #1;   // accept edge
        in_valid = 1'b0;
        @(posedge clk); #1;   // now converting minutes
        rst = 1'b1;
        @(posedge clk); #1;
        check_fields("t6_rst", 0, 0, 0, 0, 0, 0);
        chk("t6_rst.valid", 32'(out_valid), 0);
        chk("t6_rst.ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("t6_rst.ready_release", 32'(in_ready), 1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("t6_rst.no_partial", n, 0);
        xact("t6_after", 8'h07, 8'h08, 8'h09, 0);

        for (int i = 0; i < 30; i++) begin
            rs = {1'($urandom), 3'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
            rm = {1'($urandom), 3'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
            if ($urandom_range(0, 1) == 1)
                rh = {1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 10))};
            else
                rh = {1'b0, 1'($urandom), 2'($urandom_range(0, 2)), 4'($urandom_range(0, 10))};
            xact($sformatf("rand%0d", i), rs, rm, rh, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
